seg_scan_mux: RTL and testbench

Time-multiplexed seven-segment display driver that sits directly downstream of the 2-digit BCD adder/decoder stage. It consumes per-digit segment vectors (one bit per digit for each of segments a..g) and drives a single shared segment bus plus one-hot digit anodes. Inputs are snapshotted once per frame to prevent tearing, and each digit slot opens with a blanking guard to suppress ghosting.

---
 rtl/seg_scan_if.sv | 34 +++
 rtl/seg_scan_mux.sv | 125 ++++++++++++
 tb/tb_seg_scan_mux.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Bundle of signals between the BCD decoder stage and the display driver.
// The decoder side uses the master modport. The scan driver uses the slave modport.
interface seg_scan_if #(
  parameter int DIGITS = 4
) ();

  // Per-digit segment requests, active-high, bit i belongs to digit i
  logic [DIGITS-1:0] seg_a;
  logic [DIGITS-1:0] seg_b;
  logic [DIGITS-1:0] seg_c;
  logic [DIGITS-1:0] seg_d;
  logic [DIGITS-1:0] seg_e;
  logic [DIGITS-1:0] seg_f;
  logic [DIGITS-1:0] seg_g;
  logic [DIGITS-1:0] dp;
  logic [DIGITS-1:0] digit_en;

  // Shared display bus, polarity set by the driver parameters
  logic [6:0]        seg_out;
  logic              dp_out;
  logic [DIGITS-1:0] an;
  logic              frame_start;

  modport master (
    output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, dp, digit_en,
    input  seg_out, dp_out, an, frame_start
  );

  modport slave (
    input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, dp, digit_en,
    output seg_out, dp_out, an, frame_start
  );

endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver.
// The module takes one snapshot of all digit inputs per frame, so a frame never shows mixed data.
// It then scans the digits one slot at a time. Each slot opens with a few dark cycles so
// that one digit's segments never ghost onto the next digit. Every output comes from a register.
module seg_scan_mux #(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 50000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // Output levels for an unlit segment and for a disabled anode
  localparam logic SEG_OFF = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_OFF  = (AN_ACTIVE_LOW != 0);

  // One frame's worth of display data. seg[0] is segment a and seg[6] is segment g.
  typedef struct packed {
    logic [6:0][DIGITS-1:0] seg;
    logic [DIGITS-1:0]      dp;
    logic [DIGITS-1:0]      en;
  } snap_t;

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  snap_t             snap;
  snap_t             snap_next;

  logic              frame_start_q;
  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] an_q;

  logic              slot_last;
  logic              frame_top;
  logic              lit;
  logic [6:0]        lit_seg;
  logic [DIGITS-1:0] onehot;

  assign slot_last = (cnt == CNT_LAST);
  assign frame_top = (cnt == '0) && (idx == '0);

  // Arrange the raw inputs in the snapshot layout
  assign snap_next.seg = {bus.seg_g, bus.seg_f, bus.seg_e, bus.seg_d,
                          bus.seg_c, bus.seg_b, bus.seg_a};
  assign snap_next.dp  = bus.dp;
  assign snap_next.en  = bus.digit_en;

  // Decide what the current slot position shows
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    lit_seg = '0;
    lit     = (cnt >= CNT_BLANK) && snap.en[idx];
    for (int k = 0; k < 7; k++) begin
      lit_seg[k] = snap.seg[k][idx];
    end
    onehot = {{(DIGITS-1){1'b0}}, 1'b1} << idx;
  end

  // Slot prescaler and digit index
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments, so every register sees the
    // values from before the edge, whatever order the statements are in.
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (slot_last) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Snapshot captured at the top of each frame, with a one-cycle marker
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the snapshot is cleared on reset on purpose. The first frame after reset
      // loads before anything is lit, but a cleared value keeps the dark state free of X.
      snap          <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_top;
      if (frame_top) begin
        snap <= snap_next;
      end
    end
  end

  // Registered output stage. Dark during the blanking guard and for disabled digits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= {7{SEG_OFF}};
      dp_q  <= SEG_OFF;
      an_q  <= {DIGITS{AN_OFF}};
    end else if (lit) begin
      seg_q <= lit_seg ^ {7{SEG_OFF}};
      dp_q  <= snap.dp[idx] ^ SEG_OFF;
      an_q  <= onehot ^ {DIGITS{AN_OFF}};
    end else begin
      seg_q <= {7{SEG_OFF}};
      dp_q  <= SEG_OFF;
      an_q  <= {DIGITS{AN_OFF}};
    end
  end

  assign bus.seg_out     = seg_q;
  assign bus.dp_out      = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux. It uses DIGITS=4, PRESCALE=4 and BLANK_CYCLES=1.
// u_dut_lo has both polarities active-low. u_dut_hi has both polarities active-high.
// phase counts clock edges since the edge that released reset. The sample taken after
// edge k shows the state (cnt = k%4, idx = (k/4)%4) from before that edge.
module tb_seg_scan_mux;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic rst_hi_n = 1'b0;

  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(4)) bus_lo ();
  seg_scan_if #(.DIGITS(4)) bus_hi ();

  seg_scan_mux #(
    .DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) u_dut_lo (
    .clk(clk), .rst_n(rst_n), .bus(bus_lo)
  );

  seg_scan_mux #(
    .DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) u_dut_hi (
    .clk(clk), .rst_n(rst_hi_n), .bus(bus_hi)
  );

  int checks = 0;
  int passed = 0;
  int phase  = 0;

  // Active-low anode pattern for one full frame with every digit enabled
  logic [3:0] scan_an [16] = '{
    4'b1111, 4'b1110, 4'b1110, 4'b1110,
    4'b1111, 4'b1101, 4'b1101, 4'b1101,
    4'b1111, 4'b1011, 4'b1011, 4'b1011,
    4'b1111, 4'b0111, 4'b0111, 4'b0111
  };

  // Expected active-low anodes at a given phase for a given enable mask
  function automatic logic [3:0] exp_an(input int ph, input logic [3:0] en);
    int slot;
    slot = (ph / 4) % 4;
    if ((ph % 4) == 0 || !en[slot]) return 4'b1111;
    return scan_an[ph % 16];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    phase++;
  endtask

  task automatic test_reset();
    bus_lo.seg_a = '0; bus_lo.seg_b = '0; bus_lo.seg_c = '0; bus_lo.seg_d = '0;
    bus_lo.seg_e = '0; bus_lo.seg_f = '0; bus_lo.seg_g = '0; bus_lo.dp = '0;
    bus_lo.digit_en = '0;
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (bus_lo.an !== 4'b1111) $display("FAIL reset_an got=%b exp=1111", bus_lo.an); else passed++;
    checks++; if (bus_lo.seg_out !== 7'b1111111) $display("FAIL reset_seg got=%b exp=1111111", bus_lo.seg_out); else passed++;
    checks++; if (bus_lo.dp_out !== 1'b1) $display("FAIL reset_dp got=%b exp=1", bus_lo.dp_out); else passed++;
    checks++; if (bus_lo.frame_start !== 1'b0) $display("FAIL reset_fs got=%b exp=0", bus_lo.frame_start); else passed++;
  endtask

  task automatic test_scan();
    logic [3:0] ea;
    logic [6:0] es;
    bus_lo.seg_a    = 4'b1111;
    bus_lo.digit_en = 4'b1111;
    rst_n = 1'b1;
    phase = -1;
    for (int i = 0; i < 32; i++) begin
      step();
      ea = scan_an[phase % 16];
      es = (ea != 4'b1111) ? 7'b1111110 : 7'b1111111;
      checks++; if (bus_lo.an !== ea) $display("FAIL scan_an ph=%0d got=%b exp=%b", phase, bus_lo.an, ea); else passed++;
      checks++; if (bus_lo.seg_out !== es) $display("FAIL scan_seg ph=%0d got=%b exp=%b", phase, bus_lo.seg_out, es); else passed++;
      checks++; if (bus_lo.dp_out !== 1'b1) $display("FAIL scan_dp ph=%0d got=%b exp=1", phase, bus_lo.dp_out); else passed++;
      checks++; if (bus_lo.frame_start !== ((phase % 16) == 0)) $display("FAIL scan_fs ph=%0d got=%b", phase, bus_lo.frame_start); else passed++;
    end
  endtask

  task automatic test_snapshot();
    logic [3:0] ea;
    logic [6:0] es;
    for (int i = 0; i < 32; i++) begin
      step();
      ea = exp_an(phase, 4'b1111);
      es = (ea == 4'b1111) ? 7'b1111111 : ((phase >= 48) ? 7'b1111100 : 7'b1111110);
      checks++; if (bus_lo.an !== ea) $display("FAIL snap_an ph=%0d got=%b exp=%b", phase, bus_lo.an, ea); else passed++;
      checks++; if (bus_lo.seg_out !== es) $display("FAIL snap_seg ph=%0d got=%b exp=%b", phase, bus_lo.seg_out, es); else passed++;
      checks++; if (bus_lo.frame_start !== ((phase % 16) == 0)) $display("FAIL snap_fs ph=%0d got=%b", phase, bus_lo.frame_start); else passed++;
      // The change arrives during the digit 1 slot of frame 2
      if (phase == 37) bus_lo.seg_b = 4'b1111;
    end
  endtask

  task automatic test_digit_en();
    logic [3:0] ea;
    logic [6:0] es;
    bus_lo.digit_en = 4'b0101;
    for (int i = 0; i < 32; i++) begin
      step();
      ea = exp_an(phase, 4'b0101);
      es = (ea == 4'b1111) ? 7'b1111111 : 7'b1111100;
      checks++; if (bus_lo.an !== ea) $display("FAIL en_an ph=%0d got=%b exp=%b", phase, bus_lo.an, ea); else passed++;
      checks++; if (bus_lo.seg_out !== es) $display("FAIL en_seg ph=%0d got=%b exp=%b", phase, bus_lo.seg_out, es); else passed++;
      checks++; if (bus_lo.frame_start !== ((phase % 16) == 0)) $display("FAIL en_fs ph=%0d got=%b", phase, bus_lo.frame_start); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ea;
    logic [6:0] es;
    bus_lo.digit_en = 4'b1111;
    bus_lo.seg_b    = 4'b0000;
    while (phase < 105) begin
      step();
      ea = exp_an(phase, 4'b1111);
      es = (ea == 4'b1111) ? 7'b1111111 : 7'b1111110;
      checks++; if (bus_lo.an !== ea) $display("FAIL pre_rst_an ph=%0d got=%b exp=%b", phase, bus_lo.an, ea); else passed++;
      checks++; if (bus_lo.seg_out !== es) $display("FAIL pre_rst_seg ph=%0d got=%b exp=%b", phase, bus_lo.seg_out, es); else passed++;
    end
    // This point is inside the digit 2 slot, and an is lit
    rst_n = 1'b0;
    step();
    checks++; if (bus_lo.an !== 4'b1111) $display("FAIL mid_rst_an got=%b exp=1111", bus_lo.an); else passed++;
    checks++; if (bus_lo.seg_out !== 7'b1111111) $display("FAIL mid_rst_seg got=%b exp=1111111", bus_lo.seg_out); else passed++;
    checks++; if (bus_lo.dp_out !== 1'b1) $display("FAIL mid_rst_dp got=%b exp=1", bus_lo.dp_out); else passed++;
    checks++; if (bus_lo.frame_start !== 1'b0) $display("FAIL mid_rst_fs got=%b exp=0", bus_lo.frame_start); else passed++;
    rst_n = 1'b1;
    phase = -1;
    for (int i = 0; i < 16; i++) begin
      step();
      ea = scan_an[phase];
      es = (ea == 4'b1111) ? 7'b1111111 : 7'b1111110;
      checks++; if (bus_lo.an !== ea) $display("FAIL restart_an ph=%0d got=%b exp=%b", phase, bus_lo.an, ea); else passed++;
      checks++; if (bus_lo.seg_out !== es) $display("FAIL restart_seg ph=%0d got=%b exp=%b", phase, bus_lo.seg_out, es); else passed++;
      checks++; if (bus_lo.frame_start !== (phase == 0)) $display("FAIL restart_fs ph=%0d got=%b", phase, bus_lo.frame_start); else passed++;
    end
  endtask

  task automatic test_dp();
    logic [3:0] ea;
    bus_lo.seg_a = 4'b0000;
    bus_lo.dp    = 4'b1000;
    for (int i = 0; i < 16; i++) begin
      step();
      ea = exp_an(phase, 4'b1111);
      checks++; if (bus_lo.an !== ea) $display("FAIL dp_an ph=%0d got=%b exp=%b", phase, bus_lo.an, ea); else passed++;
      checks++; if (bus_lo.seg_out !== 7'b1111111) $display("FAIL dp_seg ph=%0d got=%b exp=1111111", phase, bus_lo.seg_out); else passed++;
      checks++; if (bus_lo.dp_out !== (ea != 4'b0111)) $display("FAIL dp_out ph=%0d got=%b an=%b", phase, bus_lo.dp_out, ea); else passed++;
    end
  endtask

  task automatic test_polarity();
    logic [3:0] ea;
    logic [6:0] es;
    checks++; if (bus_hi.an !== 4'b0000) $display("FAIL hi_rst_an got=%b exp=0000", bus_hi.an); else passed++;
    checks++; if (bus_hi.seg_out !== 7'b0000000) $display("FAIL hi_rst_seg got=%b exp=0000000", bus_hi.seg_out); else passed++;
    checks++; if (bus_hi.dp_out !== 1'b0) $display("FAIL hi_rst_dp got=%b exp=0", bus_hi.dp_out); else passed++;
    rst_hi_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      ea = ((k % 4) == 0) ? 4'b0000 : ~scan_an[k];
      es = (ea == 4'b0000) ? 7'b0000000 : 7'b0000001;
      checks++; if (bus_hi.an !== ea) $display("FAIL hi_an k=%0d got=%b exp=%b", k, bus_hi.an, ea); else passed++;
      checks++; if (bus_hi.seg_out !== es) $display("FAIL hi_seg k=%0d got=%b exp=%b", k, bus_hi.seg_out, es); else passed++;
      checks++; if (bus_hi.frame_start !== (k == 0)) $display("FAIL hi_fs k=%0d got=%b", k, bus_hi.frame_start); else passed++;
    end
  endtask

  initial begin
    bus_hi.seg_a = 4'b1111; bus_hi.seg_b = '0; bus_hi.seg_c = '0; bus_hi.seg_d = '0;
    bus_hi.seg_e = '0; bus_hi.seg_f = '0; bus_hi.seg_g = '0; bus_hi.dp = '0;
    bus_hi.digit_en = 4'b1111;
    test_reset();
    test_scan();
    test_snapshot();
    test_digit_en();
    test_reset_mid();
    test_dp();
    test_polarity();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
